// File: rtl/ft245_tx_arbiter_pkg.sv
// ft245_pkg: shared definitions for the FT245 TX arbiter/framer.
//   state_e        - framer FSM state encoding
//   SYNC_BYTE_DEF  - default first byte of every frame
//   ID_EOM_BIT / ID_CH_MSB - ID byte layout {eom, ch[6:0]}
//   make_id()      - assembles the ID byte
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SYNC    = 3'd2,
    ST_ID      = 3'd3,
    ST_LEN     = 3'd4,
    ST_PAYLOAD = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int ID_EOM_BIT = 7;
  localparam int ID_CH_MSB  = 6;

  function automatic logic [7:0] make_id(input logic eom, input logic [6:0] ch);
    logic [7:0] b;
    b = '0;
    b[ID_EOM_BIT]    = eom;
    b[ID_CH_MSB:0]   = ch;
    return b;
  endfunction

endpackage

// File: rtl/ft245_tx_arbiter_if.sv
// ft245_tx_arbiter_if: requester-side byte streams plus the FT245 TX path.
//   req_data/req_valid/req_last : N_CH byte streams into the arbiter
//   req_ready                   : per-channel accept, one-hot or zero
//   tx_data_si/tx_valid_si      : registered byte toward the FT245 FIFO
//   tx_ready_si                 : one-cycle "byte consumed" pulse
// slave = the arbiter, master = producers + FT245 side.
interface ft245_tx_arbiter_if #(
  parameter int N_CH = 4
) ();

  logic [8*N_CH-1:0] req_data;
  logic [N_CH-1:0]   req_valid;
  logic [N_CH-1:0]   req_last;
  logic [N_CH-1:0]   req_ready;
  logic [7:0]        tx_data_si;
  logic              tx_valid_si;
  logic              tx_ready_si;

  modport master (
    output req_data, req_valid, req_last,
    input  req_ready,
    input  tx_data_si, tx_valid_si,
    output tx_ready_si
  );

  modport slave (
    input  req_data, req_valid, req_last,
    output req_ready,
    output tx_data_si, tx_valid_si,
    input  tx_ready_si
  );

endinterface

// File: rtl/ft245_tx_arbiter_byte_fifo.sv
// byte_fifo: synchronous 8-bit FIFO holding one burst.
//   clk, rst     - clock, synchronous active-high reset
//   flush_i      - empties the FIFO (pointers and count) on the next edge
//   push_i/data_i- write one byte (ignored when full)
//   pop_i/data_o - data_o shows the head; pop_i advances it (ignored when empty)
//   count_o      - bytes currently stored
module byte_fifo #(
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign push_ok = push_i && (count_q != CNT_FULL);
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the count gates what is ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: round-robin arbiter + framer sharing the FT245 TX path.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of ft245_tx_arbiter_if (requesters in, FT245 TX out)
// A burst of up to MAX_BURST bytes is collected from the granted channel,
// then emitted as SYNC, ID {eom, ch}, LEN, payload.
//
// state   | meaning
// IDLE    | pick next valid channel round-robin after last_grant
// FILL    | accept bytes from granted channel into the burst FIFO
// SYNC    | presenting SYNC_BYTE
// ID      | presenting {eom, channel}
// LEN     | presenting burst length
// PAYLOAD | presenting buffered bytes; return to IDLE after the last one
module ft245_tx_arbiter
  import ft245_pkg::*;
#(
  parameter int         N_CH         = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         FILL_TIMEOUT = 256,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input logic               clk,
  input logic               rst,
  ft245_tx_arbiter_if.slave bus
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(FILL_TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [TW-1:0] TMO_MAX = TW'(FILL_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          eom_q, eom_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic [N_CH-1:0] req_ready_o;
  logic            accept;
  logic [7:0]      acc_data;
  logic            acc_last;
  logic            tx_fire;
  logic            rr_found;
  logic [IW-1:0]   rr_pick;
  logic            fifo_push, fifo_pop, fifo_flush;
  logic [7:0]      fifo_data;
  logic [CW-1:0]   fifo_count;
  logic [TW-1:0]   tmo_inc;

  byte_fifo #(
    .DEPTH (MAX_BURST),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (acc_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );

  assign acc_data = bus.req_data[8*int'(grant_q) +: 8];
  assign acc_last = bus.req_last[grant_q];
  assign accept   = req_ready_o[grant_q] && bus.req_valid[grant_q];
  // A ready pulse without a presented byte is not a handshake.
  assign tx_fire  = tx_valid_q && bus.tx_ready_si;
  assign tmo_inc  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_ONE;

  // Round-robin: first valid channel at or after last_grant+1, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_pick  = last_grant_q;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last_grant_q) + i) % N_CH;
      if (!rr_found && bus.req_valid[idx]) begin
        rr_found = 1'b1;
        rr_pick  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(N_CH - 1);
      count_q      <= '0;
      tmo_q        <= '0;
      eom_q        <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
      eom_q        <= eom_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    tmo_d        = tmo_q;
    eom_d        = eom_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          count_d = '0;
          tmo_d   = '0;
          eom_d   = 1'b0;
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        if (accept) begin
          count_d = count_q + CNT_ONE;
          tmo_d   = '0;
          // req_last takes precedence over a full burst for eom.
          if (acc_last || (count_q + CNT_ONE == CNT_MAX)) begin
            eom_d      = acc_last;
            state_d    = ST_SYNC;
            tx_valid_d = 1'b1;
            tx_data_d  = SYNC_BYTE;
          end
        end else begin
          tmo_d = tmo_inc;
          if ((tmo_inc == TMO_MAX) && (count_q != '0)) begin
            eom_d      = 1'b0;
            state_d    = ST_SYNC;
            tx_valid_d = 1'b1;
            tx_data_d  = SYNC_BYTE;
          end
        end
      end

      ST_SYNC: begin
        if (tx_fire) begin
          tx_data_d = make_id(eom_q, 7'(grant_q));
          state_d   = ST_ID;
        end
      end

      ST_ID: begin
        if (tx_fire) begin
          tx_data_d = 8'(count_q);
          state_d   = ST_LEN;
        end
      end

      ST_LEN: begin
        if (tx_fire) begin
          tx_data_d = fifo_data;
          state_d   = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (tx_fire) begin
          if (fifo_count == '0) begin
            tx_valid_d   = 1'b0;
            tx_data_d    = '0;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            tx_data_d = fifo_data;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if ((state_q == ST_FILL) && (count_q < CNT_MAX)) req_ready_o[grant_q] = 1'b1;
    fifo_push  = accept;
    // The head byte is moved into the output register as the previous byte fires.
    fifo_pop   = tx_fire && ((state_q == ST_LEN) || (state_q == ST_PAYLOAD));
    fifo_flush = (state_q == ST_IDLE);
  end

  assign bus.req_ready   = req_ready_o;
  assign bus.tx_data_si  = tx_data_q;
  assign bus.tx_valid_si = tx_valid_q;

endmodule
